// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity and frame-length helpers.
// Also used by the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

  function automatic int unsigned frame_cycles(input int unsigned word_length,
                                               input int unsigned clks_per_bit,
                                               input int unsigned parity_en);
    return (2 + word_length + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO buffering words for the UART transmitter.
// Pointers carry one extra wrap bit so full and empty come from their difference.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    wr_ptr_d = (wr_en && !full)  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = (rd_en && !empty) ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed frame FSM driving a registered serial line.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line high, waiting for a word in the FIFO
// ST_START  | start bit (line low)
// ST_DATA   | data bits, LSB first, from the shift register
// ST_PARITY | even-parity bit (only when PARITY_EN)
// ST_STOP   | stop bit (line high); chains straight into the next frame
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] DATATX,
  input  logic                   Transmit,
  output logic                   SerialDataOut,
  output logic                   TX_Busy,
  output logic                   TX_Full,
  output logic                   TX_Done,
  output logic                   TX_Overflow
);

  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int BIW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [BW-1:0]  LAST_BAUD = BW'(CLKS_PER_BIT - 1);
  localparam logic [BIW-1:0] LAST_BIT  = BIW'(WORD_LENGTH - 1);

  tx_state_e              state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [BIW-1:0]         bit_q, bit_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   line_q, line_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;

  logic                   fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [WORD_LENGTH-1:0] fifo_data;
  logic                   baud_last;

  // A write while full is dropped even if the FSM pops in the same cycle.
  assign fifo_wr = Transmit && !fifo_full;

  uart_tx_fifo #(
    .WIDTH (WORD_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (DATATX),
    .rd_en   (fifo_rd),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_last = (baud_q == LAST_BAUD);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    done_d   = 1'b0;
    fifo_rd  = 1'b0;
    ovf_d    = ovf_q | (Transmit & fifo_full);

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_rd  = 1'b1;
          shift_d  = fifo_data;
          parity_d = even_parity(32'(fifo_data));
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          done_d = 1'b1;
          if (!fifo_empty) begin
            fifo_rd  = 1'b1;
            shift_d  = fifo_data;
            parity_d = even_parity(32'(fifo_data));
            state_d  = ST_START;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line is registered from the current state, so it trails state_q by one cycle.
    case (state_q)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_q[0];
      ST_PARITY: line_d = parity_q;
      default:   line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      line_q   <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      line_q   <= line_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign SerialDataOut = line_q;
  assign TX_Done       = done_q;
  assign TX_Overflow   = ovf_q;
  assign TX_Full       = fifo_full;
  assign TX_Busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered: cycle-exact frame checks plus a behavioural line
// decoder that compares every received frame against a queue of expected words.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = '0, data_np = '0;
  logic       tx = 1'b0, tx_np = 1'b0;
  logic       line, busy, full, done, ovf;
  logic       line_np, busy_np, full_np, done_np, ovf_np;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .WORD_LENGTH(8), .CLKS_PER_BIT(16), .FIFO_DEPTH(4), .PARITY_EN(1)
  ) u_dut (
    .clk(clk), .reset(reset), .DATATX(data), .Transmit(tx),
    .SerialDataOut(line), .TX_Busy(busy), .TX_Full(full),
    .TX_Done(done), .TX_Overflow(ovf)
  );

  uart_tx_buffered #(
    .WORD_LENGTH(8), .CLKS_PER_BIT(16), .FIFO_DEPTH(4), .PARITY_EN(0)
  ) u_dut_np (
    .clk(clk), .reset(reset), .DATATX(data_np), .Transmit(tx_np),
    .SerialDataOut(line_np), .TX_Busy(busy_np), .TX_Full(full_np),
    .TX_Done(done_np), .TX_Overflow(ovf_np)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         done_cnt = 0;
  bit         dec_active = 1'b0;
  int         dec_t = 0;
  logic [10:0] dec_bits = '0;
  bit         gap_en = 1'b0;
  int         last_start = -1;
  logic [7:0] ovf_words [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h5A};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Receiver model for the main DUT: mid-bit sampling of an 11-slot frame (16 clk/slot).
  always @(negedge clk) begin
    logic [7:0] w;
    cyc++;
    if (done) done_cnt++;
    if (reset) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (line == 1'b0) begin
        dec_active = 1'b1;
        dec_t = 0;
        if (gap_en && last_start >= 0) check_eq("b2b_gap", 32'(cyc - last_start), 32'd176);
        last_start = gap_en ? cyc : -1;
      end
    end else begin
      dec_t++;
      if (dec_t % 16 == 8) begin
        dec_bits[dec_t / 16] = line;
        if (dec_t / 16 == 10) begin
          dec_active = 1'b0;
          if (exp_q.size() == 0) begin
            check_eq("rx_unexpected_frame", 32'd1, 32'd0);
          end else begin
            w = exp_q.pop_front();
            check_eq("rx_word", 32'(dec_bits[8:1]), 32'(w));
            check_eq("rx_parity", 32'(dec_bits[9]), 32'(^w));
            check_eq("rx_start_stop", 32'({dec_bits[0], dec_bits[10]}), 32'b01);
          end
        end
      end
    end
  end

  task automatic push_word(input bit np, input logic [7:0] w);
    @(negedge clk);
    if (np) begin data_np = w; tx_np = 1'b1; end
    else    begin data = w;    tx = 1'b1;    end
    @(posedge clk);
    #1;
    tx = 1'b0;
    tx_np = 1'b0;
  endtask

  // Pushes one word into an idle DUT and checks the whole line waveform cycle by cycle.
  task automatic push_and_watch(input bit np, input logic [7:0] w, input string tag);
    int nsl, errs, dones, first_done;
    logic [10:0] fr;
    logic l, d, busy_pre, busy_end;
    nsl = np ? 10 : 11;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = w;
    if (!np) fr[9] = ^w;
    if (!np) exp_q.push_back(w);
    push_word(np, w);
    @(negedge clk);
    check_eq({tag, "_line_edge_n"}, 32'(np ? line_np : line), 32'd1);
    @(negedge clk);
    check_eq({tag, "_line_edge_n1"}, 32'(np ? line_np : line), 32'd1);
    errs = 0; dones = 0; first_done = -1; busy_pre = 1'b0; busy_end = 1'b1;
    for (int k = 0; k < nsl * 16; k++) begin
      @(negedge clk);
      l = np ? line_np : line;
      d = np ? done_np : done;
      if (l !== fr[k / 16]) errs++;
      if (d) begin
        dones++;
        if (first_done < 0) first_done = k;
      end
      if (k == nsl * 16 - 2) busy_pre = np ? busy_np : busy;
      if (k == nsl * 16 - 1) busy_end = np ? busy_np : busy;
    end
    check_eq({tag, "_wave_errors"}, 32'(errs), 32'd0);
    check_eq({tag, "_done_pulses"}, 32'(dones), 32'd1);
    check_eq({tag, "_frame_len"}, 32'(first_done + 1), 32'((2 + 8 + (np ? 0 : 1)) * 16));
    check_eq({tag, "_busy_in_stop"}, 32'(busy_pre), 32'd1);
    check_eq({tag, "_busy_after"}, 32'(busy_end), 32'd0);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int t = 0;
    while ((busy || exp_q.size() != 0 || dec_active) && t < bound) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_drain_in_time"}, 32'(t < bound), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_not_full(input int bound, input string tag);
    int t = 0;
    while (full && t < bound) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_not_full_in_time"}, 32'(t < bound), 32'd1);
  endtask

  initial begin
    int d0;
    logic [7:0] w;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_line", 32'(line), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_np_line", 32'(line_np), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    push_and_watch(1'b0, 8'h69, "single_69");
    push_and_watch(1'b0, 8'h07, "odd_07");
    push_and_watch(1'b1, 8'h07, "nopar_07");
    wait_idle(100, "directed");

    d0 = done_cnt;
    for (int i = 0; i < 12; i++) begin
      wait_not_full(1000, "rand");
      w = 8'($urandom);
      exp_q.push_back(w);
      push_word(1'b0, w);
      repeat ($urandom_range(0, 200)) @(negedge clk);
    end
    wait_idle(5000, "rand");
    check_eq("rand_done_count", 32'(done_cnt - d0), 32'd12);
    check_eq("rand_no_overflow", 32'(ovf), 32'd0);

    // Six consecutive writes: the first is popped at once, so the FIFO fills on the fifth.
    d0 = done_cnt;
    gap_en = 1'b1;
    last_start = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data = ovf_words[i];
      tx = 1'b1;
      if (i < 5) exp_q.push_back(ovf_words[i]);
      @(posedge clk);
      #1;
      check_eq($sformatf("ovf_full_after_wr%0d", i), 32'(full), 32'(i >= 4));
      check_eq($sformatf("ovf_flag_after_wr%0d", i), 32'(ovf), 32'(i == 5));
    end
    tx = 1'b0;
    wait_not_full(400, "ovf");
    exp_q.push_back(8'h33);
    push_word(1'b0, 8'h33);
    wait_idle(3000, "ovf");
    gap_en = 1'b0;
    check_eq("ovf_done_count", 32'(done_cnt - d0), 32'd6);
    check_eq("ovf_sticky", 32'(ovf), 32'd1);

    push_word(1'b0, 8'hF7);
    repeat (70) @(negedge clk);
    check_eq("midrst_bit3_low", 32'(line), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_line", 32'(line), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_full", 32'(full), 32'd0);
    check_eq("midrst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midrst_idle_line", 32'(line), 32'd1);
    push_and_watch(1'b0, 8'hE1, "post_rst");
    wait_idle(100, "final");
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
